// File: rtl/score_level_keeper.sv
// score_level_keeper
// Turns one-cycle gameplay event pulses into the registered score, level,
// lives and high-score values shown on the HUD. It covers ghost-combo
// doubling, fruit value by level, the single bonus life and score saturation
// at the largest 7-digit value.
module score_level_keeper #(
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned EXTRA_LIFE_AT = 10000,
    parameter int unsigned MAX_LEVEL     = 255,
    parameter int unsigned CLEAR_HOLD    = 120,
    parameter int unsigned SCORE_MAX     = 9999999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_start,
    input  logic        pellet_eaten,
    input  logic        power_eaten,
    input  logic        ghost_eaten,
    input  logic        fruit_eaten,
    input  logic        pacman_dies,
    input  logic        level_clear,
    output logic [31:0] score,
    output logic [31:0] level,
    output logic [3:0]  lives,
    output logic [31:0] high_score,
    output logic        extra_life,
    output logic        playing
);

    // The hold counter needs to reach CLEAR_HOLD-1. It is at least 1 bit wide.
    localparam int unsigned CNT_W = (CLEAR_HOLD > 1) ? $clog2(CLEAR_HOLD) : 1;

    localparam logic [32:0]      SCORE_MAX_W  = 33'(SCORE_MAX);
    localparam logic [31:0]      EXTRA_AT_W   = 32'(EXTRA_LIFE_AT);
    localparam logic [31:0]      MAX_LEVEL_W  = 32'(MAX_LEVEL);
    localparam logic [3:0]       START_LIVES_W = 4'(START_LIVES);
    localparam logic [CNT_W-1:0] HOLD_LAST_W  = CNT_W'(CLEAR_HOLD - 1);
    localparam logic [31:0]      GHOST_BASE   = 32'd200;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAY      = 2'd1,
        ST_LEVEL_END = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    // Bonus fruit points for the current level. Levels 13 and above use the top value.
    function automatic logic [31:0] fruit_value(input logic [31:0] lvl);
        logic [31:0] v;
        if (lvl <= 32'd1) begin
            v = 32'd100;
        end else if (lvl == 32'd2) begin
            v = 32'd300;
        end else if (lvl <= 32'd4) begin
            v = 32'd500;
        end else if (lvl <= 32'd6) begin
            v = 32'd700;
        end else if (lvl <= 32'd8) begin
            v = 32'd1000;
        end else if (lvl <= 32'd10) begin
            v = 32'd2000;
        end else if (lvl <= 32'd12) begin
            v = 32'd3000;
        end else begin
            v = 32'd5000;
        end
        return v;
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      score_q, score_d;
    logic [31:0]      level_q, level_d;
    logic [3:0]       lives_q, lives_d;
    logic [31:0]      high_score_q, high_score_d;
    logic             extra_life_q, extra_life_d;
    logic             playing_q, playing_d;
    logic [1:0]       combo_q, combo_d;
    logic             bonus_given_q, bonus_given_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]  combo_eff_s;
    logic [1:0]  combo_next_s;
    logic [31:0] ghost_pts_s;
    logic [31:0] fruit_pts_s;
    logic [31:0] delta_s;
    logic [32:0] score_sum_s;
    logic [31:0] score_new_s;
    logic        bonus_hit_s;
    logic [3:0]  lives_bonus_s;
    logic [31:0] level_next_s;

    // Scoring datapath: the points earned this cycle, the saturated score and the bonus-life trigger.
    always_comb begin
        // A power pellet restarts the combo before any ghost eaten in the same cycle is valued.
        combo_eff_s = power_eaten ? 2'd0 : combo_q;
        if (ghost_eaten) begin
            ghost_pts_s  = GHOST_BASE << combo_eff_s;
            combo_next_s = (combo_eff_s == 2'd3) ? 2'd3 : combo_eff_s + 2'd1;
        end else begin
            ghost_pts_s  = 32'd0;
            combo_next_s = combo_eff_s;
        end
        fruit_pts_s = fruit_eaten ? fruit_value(level_q) : 32'd0;
        delta_s     = (pellet_eaten ? 32'd10 : 32'd0)
                    + (power_eaten  ? 32'd50 : 32'd0)
                    + ghost_pts_s + fruit_pts_s;
        // The adder is one bit wider than the score, so the sum cannot wrap before it is clamped.
        score_sum_s = {1'b0, score_q} + {1'b0, delta_s};
        if (score_sum_s > SCORE_MAX_W) begin
            score_new_s = SCORE_MAX_W[31:0];
        end else begin
            score_new_s = score_sum_s[31:0];
        end
        bonus_hit_s   = (score_new_s >= EXTRA_AT_W) && !bonus_given_q;
        lives_bonus_s = (lives_q == 4'd15) ? 4'd15 : lives_q + 4'd1;
        level_next_s  = (level_q >= MAX_LEVEL_W) ? MAX_LEVEL_W : level_q + 32'd1;
    end

    // Game FSM next-state logic and the next value of every registered output.
    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        level_d       = level_q;
        lives_d       = lives_q;
        high_score_d  = high_score_q;
        combo_d       = combo_q;
        bonus_given_d = bonus_given_q;
        cnt_d         = cnt_q;
        extra_life_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (game_start) begin
                    state_d       = ST_PLAY;
                    score_d       = 32'd0;
                    level_d       = 32'd1;
                    lives_d       = START_LIVES_W;
                    combo_d       = 2'd0;
                    bonus_given_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_PLAY: begin
                // Points always land first. Clear or death handling follows.
                score_d = score_new_s;
                combo_d = combo_next_s;
                if (bonus_hit_s) begin
                    lives_d       = lives_bonus_s;
                    extra_life_d  = 1'b1;
                    bonus_given_d = 1'b1;
                end else begin
                    lives_d = lives_q;
                end

                if (level_clear) begin
                    // Clearing the maze wins over a same-cycle death.
                    state_d = ST_LEVEL_END;
                    level_d = level_next_s;
                    combo_d = 2'd0;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (pacman_dies) begin
                    combo_d = 2'd0;
                    if (bonus_hit_s) begin
                        // The bonus life cancels this death, so the game goes on.
                        lives_d = lives_q;
                    end else if (lives_q <= 4'd1) begin
                        lives_d = 4'd0;
                        state_d = ST_GAME_OVER;
                    end else begin
                        lives_d = lives_q - 4'd1;
                    end
                end else begin
                    state_d = ST_PLAY;
                end
            end

            ST_LEVEL_END: begin
                if (cnt_q == HOLD_LAST_W) begin
                    state_d = ST_PLAY;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            ST_GAME_OVER: begin
                // The score is frozen here, so the comparison settles one cycle after entry.
                if (score_q > high_score_q) begin
                    high_score_d = score_q;
                end else begin
                    high_score_d = high_score_q;
                end
                if (game_start) begin
                    state_d       = ST_PLAY;
                    score_d       = 32'd0;
                    level_d       = 32'd1;
                    lives_d       = START_LIVES_W;
                    combo_d       = 2'd0;
                    bonus_given_d = 1'b0;
                end else begin
                    state_d = ST_GAME_OVER;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        playing_d = (state_d == ST_PLAY);
    end

    // State and output registers, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            score_q       <= 32'd0;
            level_q       <= 32'd1;
            lives_q       <= 4'd0;
            high_score_q  <= 32'd0;
            extra_life_q  <= 1'b0;
            playing_q     <= 1'b0;
            combo_q       <= 2'd0;
            bonus_given_q <= 1'b0;
            cnt_q         <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            level_q       <= level_d;
            lives_q       <= lives_d;
            high_score_q  <= high_score_d;
            extra_life_q  <= extra_life_d;
            playing_q     <= playing_d;
            combo_q       <= combo_d;
            bonus_given_q <= bonus_given_d;
            cnt_q         <= cnt_d;
        end
    end

    assign score      = score_q;
    assign level      = level_q;
    assign lives      = lives_q;
    assign high_score = high_score_q;
    assign extra_life = extra_life_q;
    assign playing    = playing_q;

endmodule

// File: tb/tb_score_level_keeper.sv
// Testbench for score_level_keeper: directed scenarios plus a randomized run,
// all compared against a game-rules reference model.
module tb_score_level_keeper;

    localparam int HOLD = 120;
    // Event vector bits: 0 start, 1 pellet, 2 power, 3 ghost, 4 fruit, 5 die, 6 clear
    localparam logic [6:0] E_GS = 7'b0000001;
    localparam logic [6:0] E_PE = 7'b0000010;
    localparam logic [6:0] E_PW = 7'b0000100;
    localparam logic [6:0] E_GH = 7'b0001000;
    localparam logic [6:0] E_FR = 7'b0010000;
    localparam logic [6:0] E_DI = 7'b0100000;
    localparam logic [6:0] E_LC = 7'b1000000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic game_start = 1'b0, pellet_eaten = 1'b0, power_eaten = 1'b0, ghost_eaten = 1'b0;
    logic fruit_eaten = 1'b0, pacman_dies = 1'b0, level_clear = 1'b0;
    logic [31:0] score, level, high_score;
    logic [3:0]  lives;
    logic        extra_life, playing;

    int checks = 0;
    int failures = 0;

    // Reference model of the game rules. Mode: 0 idle, 1 play, 2 level end, 3 game over.
    int     m_mode;
    longint m_score, m_hs;
    int     m_level, m_lives, m_combo, m_hold;
    bit     m_bonus, m_extra;

    always #5 clk = ~clk;

    score_level_keeper dut (
        .clk(clk), .reset(reset), .game_start(game_start), .pellet_eaten(pellet_eaten),
        .power_eaten(power_eaten), .ghost_eaten(ghost_eaten), .fruit_eaten(fruit_eaten),
        .pacman_dies(pacman_dies), .level_clear(level_clear), .score(score), .level(level),
        .lives(lives), .high_score(high_score), .extra_life(extra_life), .playing(playing)
    );

    function automatic int fruit_of(input int lvl);
        case (lvl)
            1: return 100;
            2: return 300;
            3, 4: return 500;
            5, 6: return 700;
            7, 8: return 1000;
            9, 10: return 2000;
            11, 12: return 3000;
            default: return 5000;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_score = 0; m_hs = 0; m_level = 1; m_lives = 0;
        m_combo = 0; m_hold = 0; m_bonus = 0; m_extra = 0;
    endtask

    task automatic model_new_game();
        m_mode = 1; m_score = 0; m_level = 1; m_lives = 3; m_combo = 0; m_bonus = 0;
    endtask

    task automatic model_step(input logic [6:0] ev);
        longint pts;
        int     pre_lives;
        bit     gained;
        m_extra = 0;
        case (m_mode)
            0: if (ev[0]) model_new_game();
            1: begin
                pre_lives = m_lives;
                gained = 0;
                if (ev[2]) m_combo = 0;
                pts = 0;
                if (ev[1]) pts += 10;
                if (ev[2]) pts += 50;
                if (ev[3]) begin
                    pts += 200 * (2 ** m_combo);
                    if (m_combo < 3) m_combo++;
                end
                if (ev[4]) pts += fruit_of(m_level);
                m_score = m_score + pts;
                if (m_score > 9999999) m_score = 9999999;
                if (m_score >= 10000 && !m_bonus) begin
                    m_bonus = 1; m_extra = 1; gained = 1;
                    m_lives = (m_lives >= 15) ? 15 : m_lives + 1;
                end
                if (ev[6]) begin
                    m_level = (m_level >= 255) ? 255 : m_level + 1;
                    m_combo = 0; m_mode = 2; m_hold = 0;
                end else if (ev[5]) begin
                    m_combo = 0;
                    if (gained) m_lives = pre_lives;
                    else if (m_lives <= 1) begin m_lives = 0; m_mode = 3; end
                    else m_lives = m_lives - 1;
                end
            end
            2: begin
                m_hold++;
                if (m_hold == HOLD) m_mode = 1;
            end
            default: begin
                if (m_score > m_hs) m_hs = m_score;
                if (ev[0]) model_new_game();
            end
        endcase
    endtask

    // One clock: drive events, step the model alongside the DUT, then clear the events.
    task automatic tick(input logic [6:0] ev);
        {level_clear, pacman_dies, fruit_eaten, ghost_eaten, power_eaten, pellet_eaten, game_start} = ev;
        @(posedge clk);
        #1;
        model_step(ev);
        {level_clear, pacman_dies, fruit_eaten, ghost_eaten, power_eaten, pellet_eaten, game_start} = 7'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 6;
        if (score !== 32'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
        if (level !== 32'd1) begin failures++; $display("FAIL reset_level got=%0d exp=1", level); end
        if (lives !== 4'd0) begin failures++; $display("FAIL reset_lives got=%0d exp=0", lives); end
        if (high_score !== 32'd0) begin failures++; $display("FAIL reset_hs got=%0d exp=0", high_score); end
        if (extra_life !== 1'b0) begin failures++; $display("FAIL reset_extra got=%0b exp=0", extra_life); end
        if (playing !== 1'b0) begin failures++; $display("FAIL reset_playing got=%0b exp=0", playing); end
    endtask

    task automatic test_start();
        tick(E_GS);
        checks += 4;
        if (score !== 32'd0) begin failures++; $display("FAIL start_score got=%0d exp=0", score); end
        if (level !== 32'd1) begin failures++; $display("FAIL start_level got=%0d exp=1", level); end
        if (lives !== 4'd3) begin failures++; $display("FAIL start_lives got=%0d exp=3", lives); end
        if (playing !== 1'b1) begin failures++; $display("FAIL start_playing got=%0b exp=1", playing); end
    endtask

    task automatic test_pellets();
        repeat (3) tick(E_PE);
        checks++;
        if (score !== 32'd30) begin failures++; $display("FAIL pellets3 got=%0d exp=30", score); end
        tick(E_PE | E_PW);
        checks++;
        if (score !== 32'd90) begin failures++; $display("FAIL pellet_power got=%0d exp=90", score); end
    endtask

    task automatic test_ghost_combo();
        int inc[5] = '{200, 400, 800, 1600, 1600};
        int exp_s;
        tick(E_PW);
        exp_s = 140;
        checks++;
        if (score !== 32'(exp_s)) begin failures++; $display("FAIL power got=%0d exp=%0d", score, exp_s); end
        for (int i = 0; i < 5; i++) begin
            tick(E_GH);
            exp_s += inc[i];
            checks++;
            if (score !== 32'(exp_s)) begin failures++; $display("FAIL ghost%0d got=%0d exp=%0d", i, score, exp_s); end
        end
        tick(E_PW | E_GH);
        exp_s += 250;
        checks++;
        if (score !== 32'(exp_s)) begin failures++; $display("FAIL power_ghost got=%0d exp=%0d", score, exp_s); end
    endtask

    task automatic test_level_clear();
        int base;
        for (int n = 2; n <= 3; n++) begin
            base = int'(score);
            tick(E_LC);
            checks += 2;
            if (level !== 32'(n)) begin failures++; $display("FAIL clear_level got=%0d exp=%0d", level, n); end
            if (playing !== 1'b0) begin failures++; $display("FAIL clear_playing got=%0b exp=0", playing); end
            for (int i = 0; i < HOLD; i++) begin
                tick(7'($urandom_range(0, 127)));
                checks += 3;
                if (score !== 32'(base)) begin failures++; $display("FAIL hold_score i=%0d got=%0d exp=%0d", i, score, base); end
                if (level !== 32'(n)) begin failures++; $display("FAIL hold_level i=%0d got=%0d exp=%0d", i, level, n); end
                if (playing !== (i == HOLD - 1)) begin failures++; $display("FAIL hold_playing i=%0d got=%0b", i, playing); end
            end
        end
        base = int'(score);
        tick(E_FR);
        checks++;
        if (score !== 32'(base + 500)) begin failures++; $display("FAIL fruit_l3 got=%0d exp=%0d", score, base + 500); end
    endtask

    task automatic test_extra_life();
        int pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick(E_FR);
            if (extra_life === 1'b1) pulses++;
            checks++;
            if (extra_life !== m_extra) begin failures++; $display("FAIL extra_cycle i=%0d got=%0b exp=%0b", i, extra_life, m_extra); end
        end
        checks += 2;
        if (pulses != 1) begin failures++; $display("FAIL extra_pulses got=%0d exp=1", pulses); end
        if (lives !== 4'd4) begin failures++; $display("FAIL extra_lives got=%0d exp=4", lives); end
    endtask

    task automatic test_clear_beats_death();
        int base = int'(score);
        tick(E_LC | E_DI | E_PE);
        checks += 4;
        if (level !== 32'd4) begin failures++; $display("FAIL lcd_level got=%0d exp=4", level); end
        if (lives !== 4'd4) begin failures++; $display("FAIL lcd_lives got=%0d exp=4", lives); end
        if (score !== 32'(base + 10)) begin failures++; $display("FAIL lcd_score got=%0d exp=%0d", score, base + 10); end
        if (playing !== 1'b0) begin failures++; $display("FAIL lcd_playing got=%0b exp=0", playing); end
        repeat (HOLD) tick(7'b0);
    endtask

    task automatic test_saturation();
        int guard = 0;
        while (m_level < 13 && guard < 20) begin
            tick(E_LC);
            repeat (HOLD) tick(7'b0);
            guard++;
        end
        tick(E_FR);
        checks++;
        if (score !== 32'(m_score)) begin failures++; $display("FAIL fruit_l13 got=%0d exp=%0d", score, m_score); end
        guard = 0;
        while (m_score + 5000 <= 9999990 && guard < 5000) begin tick(E_FR); guard++; end
        while (m_score + 50 <= 9999990 && guard < 5200) begin tick(E_PW); guard++; end
        while (m_score + 10 <= 9999990 && guard < 5400) begin tick(E_PE); guard++; end
        checks++;
        if (score !== 32'd9999990) begin failures++; $display("FAIL near_max got=%0d exp=9999990", score); end
        tick(E_GH);
        checks++;
        if (score !== 32'd9999999) begin failures++; $display("FAIL sat_ghost got=%0d exp=9999999", score); end
        tick(E_FR | E_GH | E_PW);
        checks++;
        if (score !== 32'd9999999) begin failures++; $display("FAIL sat_hold got=%0d exp=9999999", score); end
    endtask

    task automatic test_game_over();
        int guard = 0;
        while (m_mode == 1 && guard < 20) begin tick(E_DI); guard++; end
        checks += 2;
        if (playing !== 1'b0) begin failures++; $display("FAIL go_playing got=%0b exp=0", playing); end
        if (lives !== 4'd0) begin failures++; $display("FAIL go_lives got=%0d exp=0", lives); end
        tick(E_PE);
        checks += 2;
        if (high_score !== 32'd9999999) begin failures++; $display("FAIL go_hs got=%0d exp=9999999", high_score); end
        if (score !== 32'd9999999) begin failures++; $display("FAIL go_frozen got=%0d exp=9999999", score); end
        tick(E_GS);
        tick(E_PE);
        for (int i = 2; i >= 0; i--) begin
            tick(E_DI);
            checks++;
            if (lives !== 4'(i)) begin failures++; $display("FAIL death_lives got=%0d exp=%0d", lives, i); end
        end
        tick(7'b0);
        checks += 2;
        if (playing !== 1'b0) begin failures++; $display("FAIL go2_playing got=%0b exp=0", playing); end
        if (high_score !== 32'd9999999) begin failures++; $display("FAIL go2_hs got=%0d exp=9999999", high_score); end
    endtask

    task automatic test_death_bonus();
        int guard = 0;
        tick(E_GS);
        tick(E_DI);
        tick(E_DI);
        while (m_score + 360 < 10000 && guard < 100) begin
            tick(E_PE | E_PW | E_GH | E_FR);
            guard++;
        end
        tick(E_PE | E_PW | E_GH | E_FR | E_DI);
        checks += 3;
        if (extra_life !== 1'b1) begin failures++; $display("FAIL db_extra got=%0b exp=1", extra_life); end
        if (lives !== 4'd1) begin failures++; $display("FAIL db_lives got=%0d exp=1", lives); end
        if (playing !== 1'b1) begin failures++; $display("FAIL db_playing got=%0b exp=1", playing); end
    endtask

    task automatic test_reset_mid_play();
        tick(E_PE);
        apply_reset();
        checks += 5;
        if (score !== 32'd0) begin failures++; $display("FAIL mid_score got=%0d exp=0", score); end
        if (level !== 32'd1) begin failures++; $display("FAIL mid_level got=%0d exp=1", level); end
        if (lives !== 4'd0) begin failures++; $display("FAIL mid_lives got=%0d exp=0", lives); end
        if (high_score !== 32'd0) begin failures++; $display("FAIL mid_hs got=%0d exp=0", high_score); end
        if (playing !== 1'b0) begin failures++; $display("FAIL mid_playing got=%0b exp=0", playing); end
    endtask

    task automatic test_random();
        logic [6:0] ev;
        for (int i = 0; i < 4000; i++) begin
            ev = 7'b0;
            ev[0] = ($urandom_range(0, 19) == 0);
            ev[1] = ($urandom_range(0, 2) == 0);
            ev[2] = ($urandom_range(0, 9) == 0);
            ev[3] = ($urandom_range(0, 3) == 0);
            ev[4] = ($urandom_range(0, 7) == 0);
            ev[5] = ($urandom_range(0, 49) == 0);
            ev[6] = ($urandom_range(0, 79) == 0);
            tick(ev);
            checks += 7;
            if (score !== 32'(m_score)) begin failures++; $display("FAIL rnd_score i=%0d got=%0d exp=%0d", i, score, m_score); end
            if (level !== 32'(m_level)) begin failures++; $display("FAIL rnd_level i=%0d got=%0d exp=%0d", i, level, m_level); end
            if (lives !== 4'(m_lives)) begin failures++; $display("FAIL rnd_lives i=%0d got=%0d exp=%0d", i, lives, m_lives); end
            if (high_score !== 32'(m_hs)) begin failures++; $display("FAIL rnd_hs i=%0d got=%0d exp=%0d", i, high_score, m_hs); end
            if (extra_life !== m_extra) begin failures++; $display("FAIL rnd_extra i=%0d got=%0b exp=%0b", i, extra_life, m_extra); end
            if (playing !== (m_mode == 1)) begin failures++; $display("FAIL rnd_playing i=%0d got=%0b exp=%0b", i, playing, m_mode == 1); end
            if (!(m_mode == 2) && level === 32'd0) begin failures++; $display("FAIL rnd_level_zero i=%0d got=%0d exp=nonzero", i, level); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_pellets();
        test_ghost_combo();
        test_level_clear();
        test_extra_life();
        test_clear_beats_death();
        test_saturation();
        test_game_over();
        test_death_bonus();
        test_reset_mid_play();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
